// File: rtl/fp_addsub_arbiter_pkg.sv
// Shared FPU definitions for the add/sub arbiter slice.
// Holds the op encoding, the tag width and the default in-flight limit.
package fp_addsub_arbiter_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } fp_op_e;

    localparam int TAG_W = 1;
    localparam int CNT_W = 4;
    localparam int DEFAULT_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/fp_addsub_arbiter_if.sv
// Bundle of requester, issue, result and response signals.
// slave = arbiter view, master = requesters/pipeline view.
interface fp_addsub_arbiter_if;
    import fp_addsub_arbiter_pkg::*;

    logic              req0, req1;
    logic [31:0]       a0, b0, a1, b1;
    logic              op0, op1;
    logic              gnt0, gnt1;
    logic              issue_valid;
    logic [31:0]       issue_a, issue_b;
    logic              issue_op;
    logic [TAG_W-1:0]  issue_tag;
    logic              res_valid;
    logic [31:0]       res_data;
    logic [TAG_W-1:0]  res_tag;
    logic              rsp_valid0, rsp_valid1;
    logic [31:0]       rsp_data;
    logic              busy, err;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, op0, op1,
        output gnt0, gnt1,
        output issue_valid, issue_a, issue_b, issue_op, issue_tag,
        input  res_valid, res_data, res_tag,
        output rsp_valid0, rsp_valid1, rsp_data,
        output busy, err
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, op0, op1,
        input  gnt0, gnt1,
        input  issue_valid, issue_a, issue_b, issue_op, issue_tag,
        output res_valid, res_data, res_tag,
        input  rsp_valid0, rsp_valid1, rsp_data,
        input  busy, err
    );

endinterface

// File: rtl/fp_addsub_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; ptr names the preferred requester.
// Ports: req[1:0], ptr, enable in; one-hot-or-zero gnt[1:0] out.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       enable,
    output logic [1:0] gnt
);

    // A lone requester always wins; on contention ptr decides.
    assign gnt[0] = enable & req[0] & (~req[1] | ~ptr);
    assign gnt[1] = enable & req[1] & (~req[0] |  ptr);

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Arbitrates two requesters onto one shared FP add/sub pipeline,
// tracks in-flight ops and routes tagged results back.
// Ports: clk, rst (async, active-high), bus (slave modport).
module fp_addsub_arbiter
    import fp_addsub_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic                clk,
    input  logic                rst,
    fp_addsub_arbiter_if.slave  bus
);

    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_nxt;
    logic             ptr;
    logic             enable;
    logic [1:0]       gnt;
    logic             any_gnt;

    // Throttle on the registered count only, so a same-cycle
    // result never opens a slot early.
    assign enable  = !rst && (outstanding < CNT_W'(MAX_OUTSTANDING));
    assign any_gnt = |gnt;

    rr_arb2 u_arb (
        .req    ({bus.req1, bus.req0}),
        .ptr    (ptr),
        .enable (enable),
        .gnt    (gnt)
    );

    assign bus.gnt0 = gnt[0];
    assign bus.gnt1 = gnt[1];
    assign bus.busy = (outstanding != '0);

    always_comb begin
        outstanding_nxt = outstanding;
        unique case ({any_gnt, bus.res_valid})
            2'b10:   outstanding_nxt = outstanding + 1'b1;
            2'b01:   begin
                // Stray result: hold at zero, err records it.
                if (outstanding != '0)
                    outstanding_nxt = outstanding - 1'b1;
            end
            default: outstanding_nxt = outstanding;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            ptr         <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            outstanding <= outstanding_nxt;
            if (any_gnt)
                ptr <= gnt[0];
            if (bus.res_valid && outstanding == '0)
                bus.err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.issue_valid <= 1'b0;
            bus.issue_a     <= '0;
            bus.issue_b     <= '0;
            bus.issue_op    <= OP_ADD;
            bus.issue_tag   <= '0;
        end else begin
            bus.issue_valid <= any_gnt;
            if (any_gnt) begin
                bus.issue_a   <= gnt[1] ? bus.a1  : bus.a0;
                bus.issue_b   <= gnt[1] ? bus.b1  : bus.b0;
                bus.issue_op  <= gnt[1] ? bus.op1 : bus.op0;
                bus.issue_tag <= TAG_W'(gnt[1]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_valid0 <= 1'b0;
            bus.rsp_valid1 <= 1'b0;
            bus.rsp_data   <= '0;
        end else begin
            bus.rsp_valid0 <= bus.res_valid && (bus.res_tag == TAG_W'(0));
            bus.rsp_valid1 <= bus.res_valid && (bus.res_tag == TAG_W'(1));
            if (bus.res_valid)
                bus.rsp_data <= bus.res_data;
        end
    end

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Self-checking bench for fp_addsub_arbiter.
// Directed scenarios plus randomized traffic against a queue model.
module tb_fp_addsub_arbiter;

    localparam int MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fp_addsub_arbiter_if bus ();

    fp_addsub_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_cnt;
    bit          m_ptr;
    bit          m_err;
    logic        m_iv;
    logic [31:0] m_ia, m_ib;
    logic        m_iop;
    logic        m_itag;
    logic        m_r0, m_r1;
    logic [31:0] m_rd;
    bit          eg0, eg1;
    logic        og0, og1;
    bit          inflight[$];

    function automatic logic [106:0] obs_vec();
        return {bus.issue_valid, bus.issue_a, bus.issue_b, bus.issue_op,
                bus.issue_tag, bus.rsp_valid0, bus.rsp_valid1,
                bus.rsp_data, bus.busy, bus.err, dut.outstanding};
    endfunction

    function automatic logic [106:0] exp_vec();
        return {m_iv, m_ia, m_ib, m_iop, m_itag, m_r0, m_r1, m_rd,
                logic'(m_cnt != 0), logic'(m_err), 4'(m_cnt)};
    endfunction

    function automatic void model_clear();
        m_cnt = 0; m_ptr = 0; m_err = 0;
        m_iv = 0; m_ia = 0; m_ib = 0; m_iop = 0; m_itag = 0;
        m_r0 = 0; m_r1 = 0; m_rd = 0;
        inflight.delete();
    endfunction

    task automatic idle_inputs();
        bus.req0 = 0; bus.req1 = 0;
        bus.res_valid = 0; bus.res_tag = 0; bus.res_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(posedge clk); #2;
        rst = 1;
        #12;
        rst = 0;
        model_clear();
        @(posedge clk); #1;
    endtask

    // One clock: apply inputs, sample gnt, advance the model.
    task automatic cyc(input bit r0, input bit r1, input bit rv,
                       input bit rtag, input logic [31:0] rdata);
        bit e0, e1, win;
        logic [31:0] sa0, sb0, sa1, sb1;
        logic so0, so1;
        int old;
        bus.req0 = r0; bus.req1 = r1;
        bus.res_valid = rv; bus.res_tag = rtag; bus.res_data = rdata;
        #1;
        og0 = bus.gnt0; og1 = bus.gnt1;
        e0 = r0 && (m_cnt < MAX);
        e1 = r1 && (m_cnt < MAX);
        if (e0 && e1) begin
            eg0 = (m_ptr == 0); eg1 = (m_ptr == 1);
        end else begin
            eg0 = e0; eg1 = e1;
        end
        sa0 = bus.a0; sb0 = bus.b0; so0 = bus.op0;
        sa1 = bus.a1; sb1 = bus.b1; so1 = bus.op1;
        @(posedge clk); #1;
        old = m_cnt;
        m_iv = eg0 | eg1;
        if (m_iv) begin
            win = eg1;
            m_ia = win ? sa1 : sa0;
            m_ib = win ? sb1 : sb0;
            m_iop = win ? so1 : so0;
            m_itag = win;
            m_ptr = !win;
            inflight.push_back(win);
        end
        m_r0 = rv && !rtag;
        m_r1 = rv && rtag;
        if (rv) m_rd = rdata;
        if (rv && old == 0) m_err = 1;
        if (m_iv && !rv) m_cnt = old + 1;
        else if (!m_iv && rv && old > 0) m_cnt = old - 1;
        bus.res_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (obs_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_state got %h want 0", obs_vec());
        end
        n_tests++;
        if ({bus.gnt1, bus.gnt0} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_gnt got %b want 00", {bus.gnt1, bus.gnt0});
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.a0 = 32'h3F800000; bus.b0 = 32'h40000000; bus.op0 = 0;
        cyc(1, 0, 0, 0, 0);
        n_tests++;
        if ({og1, og0} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_gnt got %b want 01", {og1, og0});
        end
        n_tests++;
        if ({bus.issue_valid, bus.issue_tag, bus.issue_a}
            !== {1'b1, 1'b0, 32'h3F800000}) begin
            n_fail++;
            $display("FAIL single_issue got %b %b %h want 1 0 3f800000",
                     bus.issue_valid, bus.issue_tag, bus.issue_a);
        end
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL single_state got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_contention();
        do_reset();
        bus.a0 = $urandom; bus.b0 = $urandom; bus.op0 = 1;
        bus.a1 = $urandom; bus.b1 = $urandom; bus.op1 = 0;
        for (int i = 0; i < 5; i++) begin
            logic [1:0] want;
            want = (i == 4) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
            cyc(1, 1, 0, 0, 0);
            n_tests++;
            if ({og1, og0} !== want || {eg1, eg0} !== want) begin
                n_fail++;
                $display("FAIL contention_gnt%0d got %b want %b", i,
                         {og1, og0}, want);
            end
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL contention_state%0d got %h want %h", i,
                         obs_vec(), exp_vec());
            end
        end
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL contention_busy got %b want 1", bus.busy);
        end
    endtask

    task automatic test_simultaneous();
        cyc(0, 0, 1, 0, $urandom);
        cyc(0, 0, 1, 1, $urandom);
        bus.a0 = $urandom;
        cyc(1, 0, 1, 1, 32'hCAFE0001);
        n_tests++;
        if ({og0, dut.outstanding, bus.rsp_valid1, bus.rsp_valid0,
             bus.rsp_data} !== {1'b1, 4'd2, 1'b1, 1'b0, 32'hCAFE0001}) begin
            n_fail++;
            $display("FAIL simul got g%b cnt%0d rv%b%b %h want 1 2 10 cafe0001",
                     og0, dut.outstanding, bus.rsp_valid1, bus.rsp_valid0,
                     bus.rsp_data);
        end
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL simul_state got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_full_release();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        bus.a1 = $urandom;
        cyc(0, 1, 1, 1, 32'h12345678);
        n_tests++;
        if ({og1, og0} !== 2'b00) begin
            n_fail++;
            $display("FAIL full_nogrant got %b want 00", {og1, og0});
        end
        n_tests++;
        if ({bus.rsp_valid1, bus.rsp_valid0, dut.outstanding}
            !== {2'b10, 4'd3}) begin
            n_fail++;
            $display("FAIL full_release got rv%b%b cnt%0d want 10 3",
                     bus.rsp_valid1, bus.rsp_valid0, dut.outstanding);
        end
        cyc(0, 1, 0, 0, 0);
        n_tests++;
        if ({og1, og0} !== 2'b10) begin
            n_fail++;
            $display("FAIL full_regrant got %b want 10", {og1, og0});
        end
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL full_state got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_error();
        do_reset();
        cyc(0, 0, 1, 1, 32'hDEADBEEF);
        n_tests++;
        if ({bus.err, dut.outstanding, bus.rsp_valid1, bus.rsp_data}
            !== {1'b1, 4'd0, 1'b1, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL err_set got e%b cnt%0d rv1 %b %h want 1 0 1 deadbeef",
                     bus.err, dut.outstanding, bus.rsp_valid1, bus.rsp_data);
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        n_tests++;
        if (bus.err !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL err_sticky got %h want %h", obs_vec(), exp_vec());
        end
        do_reset();
        n_tests++;
        if (bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear got %b want 0", bus.err);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        bus.a0 = $urandom; bus.b0 = $urandom; bus.op0 = 1;
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 32'hA5A5A5A5);
        cyc(1, 0, 0, 0, 0);
        n_tests++;
        if (dut.outstanding !== 4'd3) begin
            n_fail++;
            $display("FAIL midflight_pre got %0d want 3", dut.outstanding);
        end
        bus.req0 = 1;
        #2;
        rst = 1;
        #1;
        n_tests++;
        if (obs_vec() !== '0 || bus.gnt0 !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_reset got %h g%b want 0", obs_vec(),
                     bus.gnt0);
        end
        #10;
        rst = 0;
        model_clear();
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit rv, rt;
            bus.a0 = $urandom; bus.b0 = $urandom; bus.op0 = $urandom;
            bus.a1 = $urandom; bus.b1 = $urandom; bus.op1 = $urandom;
            rv = 0; rt = 0;
            if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
                rv = 1;
                rt = inflight.pop_front();
            end
            cyc($urandom_range(0, 1), $urandom_range(0, 1), rv, rt, $urandom);
            n_tests++;
            if ({og1, og0} !== {eg1, eg0} || obs_vec() !== exp_vec()) begin
                n_fail++;
                bad++;
                if (bad < 10)
                    $display("FAIL random%0d got g%b%b %h want g%b%b %h", i,
                             og1, og0, obs_vec(), eg1, eg0, exp_vec());
            end
        end
    endtask

    initial begin
        idle_inputs();
        bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0;
        bus.op0 = 0; bus.op1 = 0;
        model_clear();
        test_reset();
        test_single();
        test_contention();
        test_simultaneous();
        test_full_release();
        test_error();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
